// File: rtl/q_add_if.sv
// q_add_if: operand/result bundle between the arithmetic wrapper and the q_add unit.
interface q_add_if #(parameter int N = 32);
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         in_valid;
    logic [N-1:0] c;
    logic         overflow;
    logic         out_valid;
    modport master(output a, b, in_valid, input c, overflow, out_valid);
    modport slave(input a, b, in_valid, output c, overflow, out_valid);
endinterface

// File: rtl/q_add.sv
// q_add: sign-magnitude Q-format adder with saturation and a one-cycle registered result.
module q_add #(
    parameter int Q = 23,
    parameter int N = 32
) (
    input logic    clk,
    input logic    reset,
    q_add_if.slave bus
);
    if (Q < 0 || Q > N - 2 || N < 2) begin : g_bad_param
        $error("q_add: need N >= 2 and 0 <= Q <= N-2");
    end
    logic         w_sa, w_sb, w_same, w_ge, w_of, w_sgn;
    logic [N-2:0] w_ma, w_mb, w_diff, w_mag;
    logic [N-1:0] w_sum, w_c;
    logic [N-1:0] r_c;
    logic         r_of, r_ov;
    assign w_sa   = bus.a[N-1];
    assign w_sb   = bus.b[N-1];
    assign w_ma   = bus.a[N-2:0];
    assign w_mb   = bus.b[N-2:0];
    assign w_same = w_sa == w_sb;
    assign w_ge   = w_ma >= w_mb;
    assign w_sum  = {1'b0, w_ma} + {1'b0, w_mb};
    assign w_diff = w_ge ? w_ma - w_mb : w_mb - w_ma;
    assign w_of   = w_same & w_sum[N-1];
    assign w_mag  = !w_same ? w_diff : w_of ? '1 : w_sum[N-2:0];
    assign w_sgn  = (w_same || w_ge) ? w_sa : w_sb;
    // A zero magnitude is always emitted as +0, which also absorbs -0 inputs.
    assign w_c    = {w_sgn & (|w_mag), w_mag};
    always_ff @(posedge clk) begin
        if (reset) begin
            r_c  <= '0;
            r_of <= 1'b0;
            r_ov <= 1'b0;
        end else begin
            r_ov <= bus.in_valid;
            if (bus.in_valid) begin
                r_c  <= w_c;
                r_of <= w_of;
            end
        end
    end
    assign bus.c         = r_c;
    assign bus.overflow  = r_of;
    assign bus.out_valid = r_ov;
endmodule

// File: tb/tb_q_add.sv
// tb_q_add: directed vectors for q_add checked against a signed-integer reference model.
module tb_q_add;
    logic clk = 1'b0;
    logic reset;
    logic go = 1'b0;
    int   vectors = 0;
    int   fails = 0;
    logic [31:0] exp_c;
    logic        exp_of, exp_ov;

    q_add_if #(.N(32)) bus();
    q_add #(.Q(23), .N(32)) dut(.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Reference: interpret as signed integers, add, clamp to the largest magnitude.
    function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y);
        longint va, vb, s, mx;
        logic   ovf;
        mx = 64'h7FFF_FFFF;
        va = x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
        vb = y[31] ? -longint'(y[30:0]) : longint'(y[30:0]);
        s = va + vb;
        ovf = (s > mx) || (s < -mx);
        if (s > mx) s = mx;
        if (s < -mx) s = -mx;
        return {ovf, s < 0, 31'(s < 0 ? -s : s)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            exp_c  <= '0;
            exp_of <= 1'b0;
            exp_ov <= 1'b0;
        end else begin
            exp_ov <= bus.in_valid;
            if (bus.in_valid) {exp_of, exp_c} <= ref_add(bus.a, bus.b);
        end
    end

    initial forever begin
        @(negedge clk);
        if (go) begin
            chk("c", bus.c, exp_c);
            chk("overflow", 32'(bus.overflow), 32'(exp_of));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        end
    end

    task automatic drive(input logic [31:0] ta, input logic [31:0] tb, input logic v, input logic r);
        @(negedge clk);
        bus.a = ta;
        bus.b = tb;
        bus.in_valid = v;
        reset = r;
    endtask

    task automatic lit(input string nm, input logic [31:0] ta, input logic [31:0] tb,
                       input logic [31:0] ec, input logic eo);
        logic [32:0] m;
        m = ref_add(ta, tb);
        chk({nm, " model"}, m[31:0], ec);
        chk({nm, " model ovf"}, 32'(m[32]), 32'(eo));
        drive(ta, tb, 1'b1, 1'b0);
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        chk(nm, bus.c, ec);
        chk({nm, " ovf"}, 32'(bus.overflow), 32'(eo));
        chk({nm, " vld"}, 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        bus.a = '0;
        bus.b = '0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        go = 1'b1;
        chk("reset c", bus.c, 32'h0);
        chk("reset vld", 32'(bus.out_valid), 32'd0);
        drive(32'h0, 32'h0, 1'b0, 1'b1);
        drive(32'h0, 32'h0, 1'b0, 1'b0);

        lit("same sign", 32'h0080_0000, 32'h00C0_0000, 32'h0140_0000, 1'b0);
        lit("mixed", 32'h0080_0000, 32'h80C0_0000, 32'h8040_0000, 1'b0);
        lit("mixed swap", 32'h80C0_0000, 32'h0080_0000, 32'h8040_0000, 1'b0);
        lit("cancel", 32'h0080_0000, 32'h8080_0000, 32'h0000_0000, 1'b0);
        lit("neg zero in", 32'h8000_0000, 32'h0040_0000, 32'h0040_0000, 1'b0);
        lit("two neg zero", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0);
        lit("sat pos", 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
        lit("sat neg", 32'hFFFF_FFFF, 32'h8000_0001, 32'hFFFF_FFFF, 1'b1);
        lit("ovf clear", 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0);

        drive(32'h0010_0000, 32'h0020_0000, 1'b1, 1'b0);
        drive(32'h8010_0000, 32'h8020_0000, 1'b1, 1'b0);
        drive(32'h7FF0_0000, 32'h0020_0000, 1'b1, 1'b0);
        drive(32'h0010_0000, 32'h8030_0000, 1'b1, 1'b0);
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        chk("stream last", bus.c, 32'h8020_0000);
        drive(32'h1234_5678, 32'h0, 1'b0, 1'b0);
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        chk("hold c", bus.c, 32'h8020_0000);
        chk("hold vld", 32'(bus.out_valid), 32'd0);

        drive(32'h0080_0000, 32'h0080_0000, 1'b1, 1'b1);
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        chk("rst mid c", bus.c, 32'h0);
        chk("rst mid ovf", 32'(bus.overflow), 32'd0);
        chk("rst mid vld", 32'(bus.out_valid), 32'd0);
        lit("resume", 32'h0080_0000, 32'h0080_0000, 32'h0100_0000, 1'b0);

        for (int i = 0; i < 40; i++)
            drive($urandom, (i % 4 == 0) ? 32'h8000_0000 : $urandom, 1'(i % 5 != 3), 1'b0);
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
